// File: rtl/freq_gate_ctrl.sv
// Frequency-meter measurement sequencer: gate window, counter clear, result latch
// and auto-ranging between 1 s / 100 ms / 10 ms gates.
module freq_gate_ctrl #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             auto_rng,
    input  logic [1:0]       rng_man,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_clr,
    output logic             gate,
    output logic [1:0]       rng,
    output logic [19:0]      res,
    output logic [1:0]       res_rng,
    output logic             ovf,
    output logic             valid
);
    localparam int unsigned TW = $clog2(CLK_HZ + 1);
    localparam logic [TW-1:0] N0_M1 = TW'(CLK_HZ - 1);
    localparam logic [TW-1:0] N1_M1 = TW'(CLK_HZ / 10 - 1);
    localparam logic [TW-1:0] N2_M1 = TW'(CLK_HZ / 100 - 1);
    localparam logic [TW-1:0] NS_M1 = TW'(SETTLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_EVAL} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    rng_sel;
    logic [TW-1:0] glen_m1;
    logic [31:0]   cnt_ext;
    logic          ov;
    logic          low;

    always_comb begin
        rng_sel = auto_rng ? rng : ((rng_man == 2'd3) ? 2'd2 : rng_man);
        case (rng_sel)
            2'd0:    glen_m1 = N0_M1;
            2'd1:    glen_m1 = N1_M1;
            default: glen_m1 = N2_M1;
        endcase
        cnt_ext = 32'(cnt_val);
        ov      = (cnt_ext >= 32'd1_000_000);
        low     = (cnt_ext < 32'd99_000);
    end

    // One timer serves both the gate window and the settle delay; both count down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            cnt_clr <= 1'b0;
            gate    <= 1'b0;
            valid   <= 1'b0;
            rng     <= '0;
            res     <= '0;
            res_rng <= '0;
            ovf     <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    gate <= 1'b0;
                    if (run) begin
                        state   <= S_CLEAR;
                        cnt_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (!run) begin
                        state <= S_IDLE;
                        gate  <= 1'b0;
                    end else begin
                        rng   <= rng_sel;
                        timer <= glen_m1;
                        state <= S_GATE;
                        gate  <= 1'b1;
                    end
                end
                S_GATE: begin
                    if (!run) begin
                        state <= S_IDLE;
                        gate  <= 1'b0;
                    end else if (timer == '0) begin
                        state <= S_SETTLE;
                        timer <= NS_M1;
                        gate  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (timer == '0) begin
                        state <= S_EVAL;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_EVAL: begin
                    if (auto_rng && ov && (rng < 2'd2)) begin
                        rng <= rng + 2'd1;
                    end else if (auto_rng && low && (rng != 2'd0)) begin
                        rng <= rng - 2'd1;
                    end else begin
                        res     <= ov ? 20'd999_999 : cnt_ext[19:0];
                        ovf     <= ov;
                        res_rng <= rng;
                        valid   <= 1'b1;
                    end
                    if (run) begin
                        state   <= S_CLEAR;
                        cnt_clr <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gate  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: directed vector table, randomized periods
// against a period-level reference model, and abort/reset sequences.
module tb_freq_gate_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        auto_rng;
    logic [1:0]  rng_man;
    logic [23:0] cnt_val;
    logic        cnt_clr;
    logic        gate;
    logic [1:0]  rng;
    logic [19:0] res;
    logic [1:0]  res_rng;
    logic        ovf;
    logic        valid;

    int checks = 0;
    int passes = 0;

    freq_gate_ctrl #(.CLK_HZ(1000), .CNT_W(24), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .run(run), .auto_rng(auto_rng), .rng_man(rng_man),
        .cnt_val(cnt_val), .cnt_clr(cnt_clr), .gate(gate), .rng(rng), .res(res),
        .res_rng(res_rng), .ovf(ovf), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic [1:0] m;
        int         c;
        int         glen;
        int         rg;
        int         v;
        int         res;
        int         rr;
        int         ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Starting at a cnt_clr sample, apply inputs and observe one full period.
    task automatic period(input string tag, input logic a, input logic [1:0] m, input int c,
                          input int eglen, input int erg, input int ev,
                          input int eres, input int err, input int eovf);
        int cyc, glen, rg, vcnt;
        cyc = 0; glen = 0; rg = -1; vcnt = 0;
        auto_rng = a; rng_man = m; cnt_val = 24'(c);
        do begin
            @(negedge clk);
            cyc++;
            if (gate) begin
                if (glen == 0) rg = int'(rng);
                glen++;
            end
            vcnt += int'(valid);
        end while (!cnt_clr && cyc < 3000);
        chk({tag, " timeout"}, int'(!cnt_clr), 0);
        chk({tag, " period"}, cyc, eglen + 4);
        chk({tag, " gate_len"}, glen, eglen);
        chk({tag, " rng"}, rg, erg);
        chk({tag, " valid_cnt"}, vcnt, ev);
        chk({tag, " valid_end"}, int'(valid), ev);
        chk({tag, " res"}, int'(res), eres);
        chk({tag, " res_rng"}, int'(res_rng), err);
        chk({tag, " ovf"}, int'(ovf), eovf);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cnt_clr"}, int'(cnt_clr), 0);
        chk({tag, " gate"}, int'(gate), 0);
        chk({tag, " valid"}, int'(valid), 0);
        chk({tag, " rng"}, int'(rng), 0);
        chk({tag, " res"}, int'(res), 0);
        chk({tag, " res_rng"}, int'(res_rng), 0);
        chk({tag, " ovf"}, int'(ovf), 0);
    endtask

    function automatic int glen_of(input int r);
        return 1000 / (10 ** r);
    endfunction

    initial begin
        int mr, mres, mrr, movf, g, c, ev, cnt, vc, cc;
        logic a;
        logic [1:0] m;
        bit ov, lo;

        //          a     m     cnt        glen rg v  res      rr ovf
        tbl[0]  = '{1'b0, 2'd0, 12_345,    1000, 0, 1, 12_345,  0, 0};
        tbl[1]  = '{1'b1, 2'd0, 1_500_000, 1000, 0, 0, 12_345,  0, 0};
        tbl[2]  = '{1'b1, 2'd0, 150_000,   100,  1, 1, 150_000, 1, 0};
        tbl[3]  = '{1'b1, 2'd0, 2_000_000, 100,  1, 0, 150_000, 1, 0};
        tbl[4]  = '{1'b1, 2'd0, 2_000_000, 10,   2, 1, 999_999, 2, 1};
        tbl[5]  = '{1'b1, 2'd0, 50_000,    10,   2, 0, 999_999, 2, 1};
        tbl[6]  = '{1'b1, 2'd0, 99_000,    100,  1, 1, 99_000,  1, 0};
        tbl[7]  = '{1'b1, 2'd0, 98_999,    100,  1, 0, 99_000,  1, 0};
        tbl[8]  = '{1'b1, 2'd0, 500_000,   1000, 0, 1, 500_000, 0, 0};
        tbl[9]  = '{1'b0, 2'd2, 1_000_000, 10,   2, 1, 999_999, 2, 1};
        tbl[10] = '{1'b0, 2'd3, 7,         10,   2, 1, 7,       2, 0};
        tbl[11] = '{1'b0, 2'd1, 0,         100,  1, 1, 0,       1, 0};

        rst = 1'b1; run = 1'b0; auto_rng = 1'b0; rng_man = 2'd0; cnt_val = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle cnt_clr", int'(cnt_clr), 0);

        run = 1'b1;
        @(negedge clk);
        chk("run_to_clr", int'(cnt_clr), 1);

        for (int unsigned i = 0; i < 12; i++) begin
            period($sformatf("vec%0d", i), tbl[i].a, tbl[i].m, tbl[i].c, tbl[i].glen,
                   tbl[i].rg, tbl[i].v, tbl[i].res, tbl[i].rr, tbl[i].ovf);
        end

        // Reference model state after the table: rng register 1, last latch 0 @ range 1.
        mr = 1; mres = 0; mrr = 1; movf = 0;
        for (int k = 0; k < 30; k++) begin
            a = ($urandom_range(0, 3) != 0);
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: c = $urandom_range(0, 98_998);
                1: c = 98_999 + $urandom_range(0, 1);
                2: c = $urandom_range(99_001, 999_998);
                3: c = 999_999 + $urandom_range(0, 1);
                4: c = $urandom_range(1_000_001, 16_777_214);
                default: c = 16_777_215;
            endcase
            g  = a ? mr : ((m > 2) ? 2 : int'(m));
            mr = g;
            ov = (c >= 1_000_000);
            lo = (c < 99_000);
            ev = 0;
            if (a && ov && g < 2) mr = g + 1;
            else if (a && lo && g > 0) mr = g - 1;
            else begin
                ev = 1; mres = ov ? 999_999 : c; mrr = g; movf = int'(ov);
            end
            period($sformatf("rnd%0d", k), a, m, c, glen_of(g), g, ev, mres, mrr, movf);
        end

        // Abort at gate cycle 500 of a manual 1 s gate.
        auto_rng = 1'b0; rng_man = 2'd0; cnt_val = 24'd4242;
        cnt = 0; cc = 0;
        while (cnt < 500 && cc < 3000) begin
            @(negedge clk);
            cc++;
            if (gate) cnt++;
        end
        chk("abort reach500", cnt, 500);
        run = 1'b0;
        @(negedge clk);
        chk("abort gate", int'(gate), 0);
        vc = 0; cc = 0;
        repeat (1100) begin
            @(negedge clk);
            vc += int'(valid);
            cc += int'(cnt_clr) + int'(gate);
        end
        chk("abort valid", vc, 0);
        chk("abort activity", cc, 0);
        chk("abort res", int'(res), mres);
        chk("abort res_rng", int'(res_rng), mrr);
        chk("abort ovf", int'(ovf), movf);
        chk("abort rng", int'(rng), 0);

        run = 1'b1;
        @(negedge clk);
        chk("rerun cnt_clr", int'(cnt_clr), 1);

        // Synchronous reset in the middle of a gate.
        cnt = 0; cc = 0;
        while (cnt < 300 && cc < 3000) begin
            @(negedge clk);
            cc++;
            if (gate) cnt++;
        end
        chk("rst reach300", cnt, 300);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst idle", int'(cnt_clr) + int'(gate) + int'(valid), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
